// File: rtl/fq_video_pkg.sv
// Shared constants and types for the frame scheduler: raster geometry,
// requester indices, reset positions and the match-timer state encoding.
package fq_video_pkg;

  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int COMMIT_LINE = 515;

  localparam int N_REQ       = 5;
  localparam int REQ_T1_VER  = 0;
  localparam int REQ_T1_HOR  = 1;
  localparam int REQ_T2_VER  = 2;
  localparam int REQ_T2_HOR  = 3;
  localparam int REQ_BALL    = 4;

  localparam logic [9:0] RST_VER = 10'd275;
  localparam logic [9:0] RST_HOR = 10'd400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } timer_state_e;

  typedef struct packed {
    logic [9:0] t1_ver;
    logic [9:0] t1_hor;
    logic [9:0] t2_ver;
    logic [9:0] t2_hor;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
  } pos_set_t;

  localparam pos_set_t RESET_POS = '{
    t1_ver: RST_VER, t1_hor: RST_HOR,
    t2_ver: RST_VER, t2_hor: RST_HOR,
    ball_x: RST_HOR, ball_y: RST_VER
  };

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer whose request is not masked; pointer moves to granted+1.
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic [N-1:0]  eligible;
  logic          found;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant    = '0;
    ptr_nxt  = ptr;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    eligible = req & ~mask;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      idx = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame-synchronous game-state update: raster mirror, arbitrated shadow
// writes, commit at the end of the active area, and the match timer.
module frame_scheduler #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int GAME_SECONDS   = 180,
  parameter int H_TOTAL        = fq_video_pkg::H_TOTAL,
  parameter int V_TOTAL        = fq_video_pkg::V_TOTAL,
  parameter int COMMIT_LINE    = fq_video_pkg::COMMIT_LINE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vga_clk,
  input  logic         start,
  input  logic         pause,
  input  logic [4:0]   req,
  input  logic [99:0]  req_data,
  output logic [4:0]   ack,
  output logic [9:0]   team1_ver_pos,
  output logic [9:0]   team1_hor_pos,
  output logic [9:0]   team2_ver_pos,
  output logic [9:0]   team2_hor_pos,
  output logic [18:0]  ball_x,
  output logic [18:0]  ball_y,
  output logic [7:0]   left_seconds,
  output logic         frame_tick,
  output logic         game_over
);

  import fq_video_pkg::*;

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [9:0]    X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    Y_COMMIT = 10'(COMMIT_LINE - 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(FRAMES_PER_SEC - 1);
  localparam logic [7:0]    SEC_LOAD = 8'(GAME_SECONDS);

  logic [9:0]    x, y;
  logic          commit, commit_en, restart, timer_run, sec_tick;
  logic [4:0]    grant;
  logic [FW-1:0] frame_cnt;
  pos_set_t      shadow, shadow_wr, committed;
  timer_state_e  state, state_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (vga_clk) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  assign commit = vga_clk && (x == X_LAST) && (y == Y_COMMIT);

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .mask  (ack),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) ack <= '0;
    else     ack <= grant;
  end

  // Shadow with this cycle's grant applied; feeding the commit from here
  // lets a write landing on the commit edge join that frame.
  always_comb begin
    shadow_wr = shadow;
    if (grant[REQ_T1_VER]) shadow_wr.t1_ver = req_data[20*REQ_T1_VER +: 10];
    if (grant[REQ_T1_HOR]) shadow_wr.t1_hor = req_data[20*REQ_T1_HOR +: 10];
    if (grant[REQ_T2_VER]) shadow_wr.t2_ver = req_data[20*REQ_T2_VER +: 10];
    if (grant[REQ_T2_HOR]) shadow_wr.t2_hor = req_data[20*REQ_T2_HOR +: 10];
    if (grant[REQ_BALL]) begin
      shadow_wr.ball_x = req_data[20*REQ_BALL      +: 10];
      shadow_wr.ball_y = req_data[20*REQ_BALL + 10 +: 10];
    end
  end

  // Players carry only a 10-bit position; their upper data bits are don't-care.
  logic unused_req_hi;
  assign unused_req_hi = ^{req_data[19:10], req_data[39:30],
                           req_data[59:50], req_data[79:70]};

  // NOTE: these registers hold the defined starting positions, so unlike a
  // plain storage array they are explicitly reset.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      shadow    <= RESET_POS;
      committed <= RESET_POS;
    end else begin
      shadow <= shadow_wr;
      if (commit_en) committed <= shadow_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= commit_en;
  end

  assign team1_ver_pos = committed.t1_ver;
  assign team1_hor_pos = committed.t1_hor;
  assign team2_ver_pos = committed.t2_ver;
  assign team2_hor_pos = committed.t2_hor;
  assign ball_x        = {9'd0, committed.ball_x};
  assign ball_y        = {9'd0, committed.ball_y};

  // Match timer: state register, next-state logic, state-decoded outputs.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  assign sec_tick = commit && timer_run && (frame_cnt == FC_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (pause)                                         state_nxt = ST_PAUSE;
        else if (left_seconds == 8'd0)                     state_nxt = ST_OVER;
        else if (sec_tick && (left_seconds == 8'd1))       state_nxt = ST_OVER;
      end
      ST_PAUSE: if (!pause) state_nxt = ST_RUN;
      ST_OVER:  if (start)  state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    game_over = (state == ST_OVER);
    timer_run = (state == ST_RUN) && !pause;
    commit_en = commit && (state != ST_OVER);
    restart   = start && (state == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      left_seconds <= SEC_LOAD;
      frame_cnt    <= '0;
    end else if (commit && timer_run) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        if (left_seconds != 8'd0) left_seconds <= left_seconds - 8'd1;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Randomized bench for frame_scheduler against a linear-raster, list-based
// reference model; runs on a reduced raster so several matches fit.
module tb_frame_scheduler;

  localparam int FPS        = 2;
  localparam int GS         = 3;
  localparam int HT         = 16;
  localparam int VT         = 12;
  localparam int CL         = 10;
  localparam int FRAME      = HT * VT;
  localparam int COMMIT_POS = CL * HT - 1;

  logic        clk = 1'b0;
  logic        rst, vga_clk, start, pause;
  logic [4:0]  req;
  logic [99:0] req_data;
  logic [4:0]  ack;
  logic [9:0]  team1_ver_pos, team1_hor_pos, team2_ver_pos, team2_hor_pos;
  logic [18:0] ball_x, ball_y;
  logic [7:0]  left_seconds;
  logic        frame_tick, game_over;

  frame_scheduler #(
    .FRAMES_PER_SEC (FPS),
    .GAME_SECONDS   (GS),
    .H_TOTAL        (HT),
    .V_TOTAL        (VT),
    .COMMIT_LINE    (CL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vga_clk       (vga_clk),
    .start         (start),
    .pause         (pause),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .team1_ver_pos (team1_ver_pos),
    .team1_hor_pos (team1_hor_pos),
    .team2_ver_pos (team2_ver_pos),
    .team2_hor_pos (team2_hor_pos),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .left_seconds  (left_seconds),
    .frame_tick    (frame_tick),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_OVER} mstate_t;

  // Reference model: index 0..3 players, 4 ball_x, 5 ball_y.
  int      m_out[6];
  int      m_sh[6];
  bit [4:0] m_ack;
  int      m_ptr, m_pos, m_left, m_fcnt, m_commits;
  bit      m_tick;
  mstate_t m_st;

  bit [4:0]  req_r;
  bit [99:0] data_r;
  bit        auto_req;
  int        req_rate;
  bit        chk_en;
  int        n_vec, n_err, dut_ticks;
  int        ack_log[$];

  string pos_name[6] = '{"team1_ver", "team1_hor", "team2_ver",
                         "team2_hor", "ball_x", "ball_y"};

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int reset_val(input int k);
    return (k == 0 || k == 2 || k == 5) ? 275 : 400;
  endfunction

  function automatic bit rv();
    return $urandom_range(0, 99) < 70;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      m_out[k] = reset_val(k);
      m_sh[k]  = reset_val(k);
    end
    m_ack = '0; m_ptr = 0; m_pos = 0; m_left = GS; m_fcnt = 0;
    m_tick = 0; m_st = M_IDLE;
  endtask

  task automatic model_step(input bit r, input bit v, input bit s, input bit p);
    int g;
    bit commit;
    int nsh[6];
    if (r) begin
      model_reset();
      return;
    end
    commit = v && (m_pos == COMMIT_POS);
    g = -1;
    for (int d = 0; d < 5; d++) begin
      int i;
      i = (m_ptr + d) % 5;
      if (g < 0 && req_r[i] && !m_ack[i]) g = i;
    end
    nsh = m_sh;
    if (g >= 0 && g < 4) nsh[g] = int'(data_r[20*g +: 10]);
    if (g == 4) begin
      nsh[4] = int'(data_r[80 +: 10]);
      nsh[5] = int'(data_r[90 +: 10]);
    end
    m_tick = commit && (m_st != M_OVER);
    if (m_st == M_OVER && s) begin
      for (int k = 0; k < 6; k++) begin
        m_sh[k]  = reset_val(k);
        m_out[k] = reset_val(k);
      end
      m_left = GS; m_fcnt = 0; m_st = M_RUN;
    end else begin
      m_sh = nsh;
      if (m_tick) m_out = nsh;
      case (m_st)
        M_IDLE:  if (s) m_st = M_RUN;
        M_RUN: begin
          if (p) m_st = M_PAUSE;
          else if (commit) begin
            m_fcnt++;
            if (m_fcnt == FPS) begin
              m_fcnt = 0;
              if (m_left > 0) m_left--;
              if (m_left == 0) m_st = M_OVER;
            end
          end
        end
        M_PAUSE: if (!p) m_st = M_RUN;
        default: ;
      endcase
    end
    if (g >= 0) m_ptr = (g + 1) % 5;
    m_ack = '0;
    if (g >= 0) m_ack[g] = 1'b1;
    if (m_tick) m_commits++;
    if (v) m_pos = (m_pos + 1) % FRAME;
  endtask

  task automatic compare();
    int obs[6];
    obs[0] = team1_ver_pos; obs[1] = team1_hor_pos;
    obs[2] = team2_ver_pos; obs[3] = team2_hor_pos;
    obs[4] = ball_x;        obs[5] = ball_y;
    check("ack", ack, m_ack);
    for (int k = 0; k < 6; k++) check(pos_name[k], obs[k], m_out[k]);
    check("left_seconds", left_seconds, m_left);
    check("frame_tick", frame_tick, m_tick);
    check("game_over", game_over, m_st == M_OVER);
  endtask

  task automatic drive_requesters();
    for (int i = 0; i < 5; i++) begin
      if (m_ack[i]) begin
        if (auto_req && $urandom_range(0, 3) == 0) data_r[20*i +: 20] = 20'($urandom);
        else req_r[i] = 1'b0;
      end else if (auto_req && !req_r[i] && $urandom_range(0, 99) < req_rate) begin
        req_r[i] = 1'b1;
        data_r[20*i +: 20] = 20'($urandom);
      end
    end
  endtask

  task automatic cycle(input bit r, input bit v, input bit s, input bit p);
    @(negedge clk);
    if (chk_en) compare();
    if (frame_tick === 1'b1) dut_ticks++;
    if (chk_en)
      for (int i = 0; i < 5; i++) if (ack[i] === 1'b1) ack_log.push_back(i);
    drive_requesters();
    rst = r; vga_clk = v; start = s; pause = p;
    req = req_r; req_data = data_r;
    model_step(r, v, s, p);
  endtask

  initial begin
    int c0, t0, n;
    rst = 1'b1; vga_clk = 1'b0; start = 1'b0; pause = 1'b0;
    req = '0; req_data = '0;
    req_r = '0; data_r = '0; auto_req = 0; req_rate = 15;
    chk_en = 0; n_vec = 0; n_err = 0; dut_ticks = 0; m_commits = 0;
    model_reset();

    // Reset, then two idle frames with no requests.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk_en = 1;
    c0 = m_commits; t0 = dut_ticks;
    for (n = 0; n < 6 * FRAME && m_commits < c0 + 2; n++) cycle(0, rv(), 0, 0);
    cycle(0, 0, 0, 0);
    check("two_frames_done", m_commits - c0, 2);
    check("ticks_two_frames", dut_ticks - t0, 2);
    check("idle_left", left_seconds, GS);

    // Ball write at mid-frame: acked next cycle, visible only after commit.
    for (n = 0; n < 3 * FRAME && m_pos != FRAME / 2; n++) cycle(0, rv(), 0, 0);
    check("mid_frame_reached", m_pos, FRAME / 2);
    req_r[4] = 1'b1;
    data_r[99:80] = {10'd100, 10'd300};
    cycle(0, 0, 0, 0);
    @(posedge clk); #1;
    check("ball_ack", ack[4], 1);
    check("ball_x_before_commit", ball_x, 400);
    c0 = m_commits;
    for (n = 0; n < 3 * FRAME && m_commits == c0; n++) cycle(0, rv(), 0, 0);
    cycle(0, 0, 0, 0);
    check("ball_x_after_commit", ball_x, 300);
    check("ball_y_after_commit", ball_y, 100);

    // Arbitration order: all five, then 0..2 to park the pointer at 3, then 3,0.
    ack_log.delete();
    req_r = 5'b11111;
    for (int i = 0; i < 5; i++) data_r[20*i +: 20] = 20'($urandom);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0);
    check("rr_all_count", ack_log.size(), 5);
    for (int k = 0; k < 5 && k < ack_log.size(); k++) check("rr_all_order", ack_log[k], k);
    ack_log.delete();
    req_r = 5'b00111;
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0);
    req_r = 5'b01001;
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0);
    check("rr_ptr3_count", ack_log.size(), 5);
    if (ack_log.size() == 5) begin
      check("rr_ptr3_g0", ack_log[0], 0);
      check("rr_ptr3_g1", ack_log[1], 1);
      check("rr_ptr3_g2", ack_log[2], 2);
      check("rr_ptr3_g3", ack_log[3], 3);
      check("rr_ptr3_g4", ack_log[4], 0);
    end

    // Random traffic while IDLE.
    auto_req = 1;
    for (int k = 0; k < 150; k++) cycle(0, rv(), 0, 0);

    // Start, one running frame, then five paused frames.
    cycle(0, rv(), 1, 0);
    c0 = m_commits;
    for (n = 0; n < 3 * FRAME && m_commits == c0; n++) cycle(0, rv(), 0, 0);
    c0 = m_commits;
    for (n = 0; n < 15 * FRAME && m_commits < c0 + 5; n++) cycle(0, rv(), 0, 1);
    cycle(0, 0, 0, 1);
    check("pause_commits", m_commits - c0, 5);
    check("pause_left", left_seconds, GS);

    // Run out the clock.
    for (n = 0; n < 25 * FRAME && m_st != M_OVER; n++) cycle(0, rv(), 0, 0);
    cycle(0, 0, 0, 0);
    check("over_flag", game_over, 1);
    check("over_left", left_seconds, 0);
    for (int k = 0; k < 2 * FRAME; k++) cycle(0, rv(), 0, 0);

    // Start coinciding with a commit edge in OVER: start wins.
    for (n = 0; n < 3 * FRAME && m_pos != COMMIT_POS; n++) cycle(0, rv(), 0, 0);
    check("commit_pos_reached", m_pos, COMMIT_POS);
    cycle(0, 1, 1, 0);
    @(posedge clk); #1;
    check("restart_left", left_seconds, GS);
    check("restart_ball_x", ball_x, 400);
    check("restart_team1_ver", team1_ver_pos, 275);
    check("restart_over", game_over, 0);
    for (int k = 0; k < 100; k++) cycle(0, rv(), 0, 0);

    // Reset mid-frame with ack[2] pending.
    auto_req = 0;
    for (int k = 0; k < 10; k++) cycle(0, rv(), 0, 0);
    req_r[2] = 1'b1;
    data_r[59:40] = 20'd123;
    cycle(0, rv(), 0, 0);
    cycle(1, 0, 0, 0);
    @(posedge clk); #1;
    check("rst_ack", ack, 0);
    check("rst_team2_ver", team2_ver_pos, 275);
    check("rst_left", left_seconds, GS);
    check("rst_tick", frame_tick, 0);
    auto_req = 1;
    for (int k = 0; k < FRAME + 100; k++) cycle(0, rv(), 0, 0);
    cycle(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
